// File: rtl/tapped_delay_line_mc_pkg.sv
// tapped_delay_line_mc_pkg: shared constants and helpers for the tapped delay line and its consumers
package tapped_delay_line_mc_pkg;
  localparam int DEFAULT_BITSIZE = 8;
  function automatic int clog2(input int v);
    int r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
  // LSB of tap k, channel c on the flat taps bus
  function automatic int tap_lsb(input int k, input int c, input int ch, input int bitsize);
    return (k * ch + c) * bitsize;
  endfunction
endpackage

// File: rtl/tapped_delay_line_mc_delay_stage_en.sv
// tapped_delay_line_mc_delay_stage_en: one CH*BITSIZE delay register with sync reset, flush and enable
// Ports: clk, reset (sync, active-high), flush (sync clear), enable (load), d (stage input), q (stage output)
module tapped_delay_line_mc_delay_stage_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         enable,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset || flush) q <= '0;
    else if (enable) q <= d;
endmodule

// File: rtl/tapped_delay_line_mc.sv
// tapped_delay_line_mc: multi-channel enable-gated tapped delay line with fill tracking and flush
// Ports: clk; reset (sync, active-high); enable (shift strobe); flush (sync clear of data and count);
//   data_in[CH*BITSIZE] (channel c at c*BITSIZE); taps[N*CH*BITSIZE] (tap k, channel c at (k*CH+c)*BITSIZE);
//   data_out (tap N-1); fill_count (valid samples, saturates at N); filled (fill_count == N);
//   tap_sel/sel_out only when TDL_TAP_SELECT_EN is defined (runtime tap mux, out-of-range picks tap N-1).
module tapped_delay_line_mc
  import tapped_delay_line_mc_pkg::*;
#(
  parameter int BITSIZE = DEFAULT_BITSIZE,
  parameter int N = 16,
  parameter int CH = 1,
  localparam int W = CH * BITSIZE,
  localparam int CW = clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic [W-1:0]     data_in,
  output logic [N*W-1:0]   taps,
  output logic [W-1:0]     data_out,
  output logic [CW-1:0]    fill_count,
  output logic             filled
`ifdef TDL_TAP_SELECT_EN
  ,
  input  logic [clog2(N)-1:0] tap_sel,
  output logic [W-1:0]        sel_out
`endif
);
  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [W-1:0] d;
    if (k == 0) begin : g_head
      assign d = data_in;
    end else begin : g_chain
      assign d = taps[tap_lsb(k - 1, 0, CH, BITSIZE) +: W];
    end
    tapped_delay_line_mc_delay_stage_en #(.W(W)) u_stage (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .enable(enable),
      .d(d),
      .q(taps[tap_lsb(k, 0, CH, BITSIZE) +: W])
    );
  end
  assign data_out = taps[tap_lsb(N - 1, 0, CH, BITSIZE) +: W];
  // filled can only rise on the increment that reaches N; once saturated nothing lowers it but a clear
  always_ff @(posedge clk)
    if (reset || flush) begin
      fill_count <= '0;
      filled <= 1'b0;
    end else if (enable && fill_count != CW'(N)) begin
      fill_count <= fill_count + CW'(1);
      filled <= fill_count == CW'(N - 1);
    end
`ifdef TDL_TAP_SELECT_EN
  int sel_idx;
  always_comb begin
    sel_idx = int'(tap_sel) >= N ? N - 1 : int'(tap_sel);
    sel_out = taps[sel_idx * W +: W];
  end
`endif
endmodule
